// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine: coin codes seen by the vending FSM
// and the coin acceptor state encoding.
`timescale 1ns/1ps
package vending_pkg;

  typedef logic [1:0] coin_t;

  localparam coin_t COIN_NONE = 2'b00;
  localparam coin_t COIN_05   = 2'b01;
  localparam coin_t COIN_10   = 2'b10;

  // Both sensors qualified high together: forwarded as a reject, never as a coin.
  localparam logic [1:0] PAT_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ACC_IDLE     = 2'd0,
    ACC_DEB      = 2'd1,
    ACC_WAIT_REL = 2'd2,
    ACC_GAP      = 2'd3
  } acc_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/coin_sync.sv
// Two-flop synchronizer for asynchronous sensor lines, reset to 0.
`timescale 1ns/1ps
module coin_sync #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  // Shift the raw lines through two stages.
  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
  end

  // Synchronizer flops.
  // NOTE: non-blocking assignments let both stages sample the old values at the same edge; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes and debounces the 5-jiao and 1-yuan
// sensors, qualifies each insertion as one coin and emits a one-cycle coin code
// or reject pulse. Define COIN_TALLY_EN to add saturating coin/reject tallies.
`timescale 1ns/1ps
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int GAP_CYCLES = 2
`ifdef COIN_TALLY_EN
  , parameter int CNT_W    = 8
`endif
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sens_05,
  input  logic             sens_10,
  output logic [1:0]       coin,
  output logic             reject
`ifdef COIN_TALLY_EN
  , input  logic             tally_clr
  , output logic [CNT_W-1:0] cnt_05
  , output logic [CNT_W-1:0] cnt_10
  , output logic [CNT_W-1:0] cnt_rej
`endif
);

  localparam int DCNT_W = $clog2(max_int(DEB_CYCLES, GAP_CYCLES) + 1);
  localparam logic [DCNT_W-1:0] DEB_LAST = DCNT_W'(DEB_CYCLES - 1);
  localparam logic [DCNT_W-1:0] GAP_LAST = DCNT_W'(GAP_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1);

  logic [1:0] s;  // {s10, s05}

  acc_state_e        state_d, state_q;
  logic [DCNT_W-1:0] dcnt_d, dcnt_q;
  logic [1:0]        pat_d, pat_q;
  coin_t             coin_d, coin_q;
  logic              reject_d, reject_q;

  coin_sync #(.WIDTH(2)) u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .async_i ({sens_10, sens_05}),
    .sync_o  (s)
  );

  // Qualification FSM: next state, counter, captured pattern and output pulse.
  // NOTE: every signal gets its default before the case so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    pat_d    = pat_q;
    coin_d   = COIN_NONE;
    reject_d = 1'b0;
    unique case (state_q)
      ACC_IDLE: begin
        if (s != 2'b00) begin
          pat_d   = s;
          dcnt_d  = DCNT_ONE;
          state_d = ACC_DEB;
        end
      end
      ACC_DEB: begin
        if (s == pat_q) begin
          if (dcnt_q == DEB_LAST) begin
            if (pat_q == PAT_BOTH) reject_d = 1'b1;
            else                   coin_d   = pat_q;
            dcnt_d  = '0;
            state_d = ACC_WAIT_REL;
          end else begin
            dcnt_d = dcnt_q + DCNT_ONE;
          end
        end else if (s == 2'b00) begin
          // Glitch: drop the partial qualification silently.
          dcnt_d  = '0;
          state_d = ACC_IDLE;
        end else begin
          // Pattern changed while still nonzero: restart on the new pattern.
          pat_d  = s;
          dcnt_d = DCNT_ONE;
        end
      end
      ACC_WAIT_REL: begin
        if (s != 2'b00) begin
          dcnt_d = '0;
        end else if (dcnt_q == DEB_LAST) begin
          dcnt_d  = '0;
          state_d = ACC_GAP;
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
        end
      end
      ACC_GAP: begin
        if (dcnt_q == GAP_LAST) begin
          dcnt_d  = '0;
          state_d = ACC_IDLE;
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
        end
      end
      default: state_d = ACC_IDLE;
    endcase
  end

  // FSM state, counter, pattern and registered output pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ACC_IDLE;
      dcnt_q   <= '0;
      pat_q    <= 2'b00;
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      pat_q    <= pat_d;
      coin_q   <= coin_d;
      reject_q <= reject_d;
    end
  end

  assign coin   = coin_q;
  assign reject = reject_q;

`ifdef COIN_TALLY_EN
  logic [CNT_W-1:0] cnt_05_d, cnt_05_q;
  logic [CNT_W-1:0] cnt_10_d, cnt_10_q;
  logic [CNT_W-1:0] cnt_rej_d, cnt_rej_q;

  // Saturating tallies driven by the output pulses; a clear beats a same-cycle pulse.
  always_comb begin
    cnt_05_d  = cnt_05_q;
    cnt_10_d  = cnt_10_q;
    cnt_rej_d = cnt_rej_q;
    if (tally_clr) begin
      cnt_05_d  = '0;
      cnt_10_d  = '0;
      cnt_rej_d = '0;
    end else begin
      if (coin_q == COIN_05 && cnt_05_q != '1) cnt_05_d  = cnt_05_q + 1'b1;
      if (coin_q == COIN_10 && cnt_10_q != '1) cnt_10_d  = cnt_10_q + 1'b1;
      if (reject_q && cnt_rej_q != '1)         cnt_rej_d = cnt_rej_q + 1'b1;
    end
  end

  // Tally registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_05_q  <= '0;
      cnt_10_q  <= '0;
      cnt_rej_q <= '0;
    end else begin
      cnt_05_q  <= cnt_05_d;
      cnt_10_q  <= cnt_10_d;
      cnt_rej_q <= cnt_rej_d;
    end
  end

  assign cnt_05  = cnt_05_q;
  assign cnt_10  = cnt_10_q;
  assign cnt_rej = cnt_rej_q;
`endif

endmodule
